bec_la_readout: RTL and testbench

Result read-back transmitter for the BEC user project: captures the 163-bit result registers from the processing core when they are ready and streams them to the management CPU over the logic-analyzer (LA) bus. Data goes out in 82-bit chunks, paced by a host acknowledge handshake. It is the outbound counterpart of the LA operand loader: the loader accepts tagged half-words from the CPU, and this block delivers tagged half-words back to it.

---
 rtl/bec_la_readout.sv | 166 ++++++++++++++++
 tb/tb_bec_la_readout.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bec_la_readout.sv
// bec_la_readout
// Captures NREG result registers from the processing core and returns them to
// the management CPU over the logic-analyzer bus. Each register is sent as two
// 82-bit chunks (high half, then low half). The host steps through the chunks
// with alternating ACK_EVEN/ACK_ODD commands.
//
// Ports:
//   wb_clk_i     block clock
//   wb_rst_n     asynchronous active-low reset
//   res_valid    core result set available (sampled only in IDLE)
//   res_data     NREG*WIDTH result bits, register k at [k*WIDTH +: WIDTH]
//   res_ready    high in IDLE, decoded from state
//   la_data_in   host command in [31:16]
//   la_oenb      command is valid only when [31:16] are all zero
//   la_data_out  {state[1:0], index[7:0], 3'b000, parity, payload[81:0], 32'h0}
//   rd_done      one-cycle pulse when the last chunk is acknowledged
module bec_la_readout #(
  parameter int WIDTH = 163,
  parameter int NREG  = 4,
  localparam int NCHUNK = 2 * NREG
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n,
  input  logic                    res_valid,
  input  logic [NREG*WIDTH-1:0]   res_data,
  output logic                    res_ready,
  input  logic [127:0]            la_data_in,
  input  logic [127:0]            la_oenb,
  output logic [127:0]            la_data_out,
  output logic                    rd_done
);

  localparam int PW  = 82;           // payload width
  localparam int LOW = WIDTH - PW;   // bits carried by an odd chunk
  localparam int RW  = $clog2(NREG);

  localparam logic [15:0] CMD_START    = 16'hAB50;
  localparam logic [15:0] CMD_ACK_EVEN = 16'hAB51;
  localparam logic [15:0] CMD_ACK_ODD  = 16'hAB52;
  localparam logic [15:0] CMD_ABORT    = 16'hAB5F;
  localparam logic [15:0] CMD_RELEASE  = 16'h0000;

  // Encodings double as the header state code.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOADED = 2'b01,
    ST_SEND   = 2'b11,
    ST_DONE   = 2'b10
  } state_t;

  state_t                  state_reg, state_next;
  logic [NREG*WIDTH-1:0]   buf_reg, buf_next;
  logic [7:0]              idx_reg, idx_next;
  logic [127:0]            out_reg, out_next;
  logic                    done_reg, done_next;
  logic [15:0]             cmd;
  logic                    ack_match;
  logic [WIDTH-1:0]        sel_word;
  logic [PW-1:0]           payload;
  logic [WIDTH-1:0]        words [NREG];

  wire unused_la = ^{la_data_in[127:32], la_data_in[15:0],
                     la_oenb[127:32], la_oenb[15:0]};

  // A gated bus reads as RELEASE.
  assign cmd = (la_oenb[31:16] == 16'h0000) ? la_data_in[31:16] : 16'h0000;

  // The matching ack depends on the parity of the current chunk index, so a
  // held code advances once and then becomes a mismatch.
  assign ack_match = idx_reg[0] ? (cmd == CMD_ACK_ODD) : (cmd == CMD_ACK_EVEN);

  for (genvar gi = 0; gi < NREG; gi++) begin : g_words
    assign words[gi] = buf_reg[gi*WIDTH +: WIDTH];
  end

  always_comb begin
    state_next = state_reg;
    buf_next   = buf_reg;
    idx_next   = idx_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (res_valid) begin
          buf_next   = res_data;
          state_next = ST_LOADED;
          idx_next   = 8'd0;
        end
      end
      ST_LOADED: begin
        if (cmd == CMD_ABORT) begin
          state_next = ST_IDLE;
          buf_next   = '0;
          idx_next   = 8'd0;
        end else if (cmd == CMD_START) begin
          state_next = ST_SEND;
          idx_next   = 8'd0;
        end
      end
      ST_SEND: begin
        if (cmd == CMD_ABORT) begin
          state_next = ST_IDLE;
          buf_next   = '0;
          idx_next   = 8'd0;
        end else if (ack_match) begin
          if (idx_reg == 8'(NCHUNK - 1)) begin
            state_next = ST_DONE;
            idx_next   = 8'd0;
            done_next  = 1'b1;
          end else begin
            idx_next = idx_reg + 8'd1;
          end
        end
      end
      ST_DONE: begin
        if (cmd == CMD_ABORT) begin
          state_next = ST_IDLE;
          buf_next   = '0;
          idx_next   = 8'd0;
        end else if (cmd == CMD_RELEASE) begin
          state_next = ST_IDLE;
          idx_next   = 8'd0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = 8'd0;
      end
    endcase
  end

  // Output word is built from the next-state values so it is registered and
  // lines up with the state it describes. The buffer never changes while in
  // SEND, so the chunk can be taken from the current buffer.
  always_comb begin
    sel_word = words[idx_next[RW:1]];
    payload  = '0;
    if (state_next == ST_SEND) begin
      if (idx_next[0])
        payload = {{(PW-LOW){1'b0}}, sel_word[LOW-1:0]};
      else
        payload = sel_word[WIDTH-1 -: PW];
    end
    out_next = {state_next, idx_next, 3'b000, ^payload, payload, 32'h0};
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_reg <= ST_IDLE;
      buf_reg   <= '0;
      idx_reg   <= 8'd0;
      out_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      buf_reg   <= buf_next;
      idx_reg   <= idx_next;
      out_reg   <= out_next;
      done_reg  <= done_next;
    end
  end

  assign res_ready   = (state_reg == ST_IDLE);
  assign la_data_out = out_reg;
  assign rd_done     = done_reg;

endmodule

// File: tb/tb_bec_la_readout.sv
// Directed bench for bec_la_readout: reset, full read-back, ack hold, busy
// ignore, abort, gating, release and mid-transfer reset.
module tb_bec_la_readout;

  localparam int WIDTH = 163;
  localparam int NREG  = 4;

  localparam logic [15:0] START    = 16'hAB50;
  localparam logic [15:0] ACK_EVEN = 16'hAB51;
  localparam logic [15:0] ACK_ODD  = 16'hAB52;
  localparam logic [15:0] ABORT    = 16'hAB5F;
  localparam logic [15:0] RELEASE  = 16'h0000;

  logic                  wb_clk_i = 1'b0;
  logic                  wb_rst_n = 1'b0;
  logic                  res_valid = 1'b0;
  logic [NREG*WIDTH-1:0] res_data = '0;
  logic                  res_ready;
  logic [127:0]          la_data_in = '0;
  logic [127:0]          la_oenb = '0;
  logic [127:0]          la_data_out;
  logic                  rd_done;

  int vectors = 0;
  int miscompares = 0;

  // Hand-chosen register halves with their hand-counted parities.
  logic [81:0] hi_v [4];
  logic [80:0] lo_v [4];
  logic        hi_p [4];
  logic        lo_p [4];
  logic [NREG*WIDTH-1:0] rich;

  bec_la_readout #(.WIDTH(WIDTH), .NREG(NREG)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_n   (wb_rst_n),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .la_data_in (la_data_in),
    .la_oenb    (la_oenb),
    .la_data_out(la_data_out),
    .rd_done    (rd_done)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  function automatic logic [127:0] mk(input logic [1:0] st, input logic [7:0] idx,
                                      input logic par, input logic [81:0] pl);
    return {st, idx, 3'b000, par, pl, 32'h0};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("vec %0d %s obs=%h", vectors, tag, obs);
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic cmd(input logic [15:0] c);
    la_data_in = {96'h0, c, 16'h1234};
  endtask

  initial begin
    hi_v[0] = 82'h2_0000_0000_0000_0000_0001; hi_p[0] = 1'b0;
    hi_v[1] = 82'h2_0000_0000_0000_0000_0002; hi_p[1] = 1'b0;
    hi_v[2] = 82'h2_0000_0000_0000_0000_0003; hi_p[2] = 1'b1;
    hi_v[3] = 82'h2_0000_0000_0000_0000_0004; hi_p[3] = 1'b0;
    lo_v[0] = 81'h1_0000_0000_0000_0000_0005; lo_p[0] = 1'b1;
    lo_v[1] = 81'h1_0000_0000_0000_0000_0015; lo_p[1] = 1'b0;
    lo_v[2] = 81'h1_0000_0000_0000_0000_0025; lo_p[2] = 1'b0;
    lo_v[3] = 81'h1_0000_0000_0000_0000_0035; lo_p[3] = 1'b1;
    for (int k = 0; k < NREG; k++) rich[k*WIDTH +: WIDTH] = {hi_v[k], lo_v[k]};

    // Reset and idle
    #3;
    chk("rst_out", la_data_out, 128'h0);
    chk("rst_ready", {127'h0, res_ready}, 128'h1);
    chk("rst_done", {127'h0, rd_done}, 128'h0);
    tick(); wb_rst_n = 1'b1; tick(); tick();
    chk("idle_out", la_data_out, 128'h0);
    chk("idle_ready", {127'h0, res_ready}, 128'h1);

    // Full read-back with register 0 = 1
    res_data = '0; res_data[0] = 1'b1; res_valid = 1'b1; tick(); res_valid = 1'b0;
    chk("cap_ready", {127'h0, res_ready}, 128'h0);
    chk("cap_loaded", la_data_out, mk(2'b01, 8'd0, 1'b0, 82'h0));
    cmd(START); tick();
    chk("fr_c0", la_data_out, mk(2'b11, 8'd0, 1'b0, 82'h0));
    for (int i = 0; i < 8; i++) begin
      cmd(i[0] ? ACK_ODD : ACK_EVEN); tick();
      if (i < 7) begin
        chk($sformatf("fr_c%0d", i + 1), la_data_out,
            mk(2'b11, 8'(i + 1), (i == 0), (i == 0) ? 82'h1 : 82'h0));
        chk($sformatf("fr_nodone%0d", i), {127'h0, rd_done}, 128'h0);
      end
    end
    chk("fr_done_hdr", la_data_out, mk(2'b10, 8'd0, 1'b0, 82'h0));
    chk("fr_done_pulse", {127'h0, rd_done}, 128'h1);
    tick();  // ACK_ODD still held: stays in DONE, pulse ends
    chk("fr_done_once", {127'h0, rd_done}, 128'h0);
    chk("fr_done_stay", la_data_out, mk(2'b10, 8'd0, 1'b0, 82'h0));
    cmd(RELEASE); tick();
    chk("fr_release", la_data_out, 128'h0);
    chk("fr_release_rdy", {127'h0, res_ready}, 128'h1);

    // Ack hold with rich data
    res_data = rich; res_valid = 1'b1; tick(); res_valid = 1'b0;
    cmd(START); tick();
    chk("ah_c0", la_data_out, mk(2'b11, 8'd0, hi_p[0], hi_v[0]));
    cmd(ACK_EVEN); tick();
    chk("ah_first", la_data_out, mk(2'b11, 8'd1, lo_p[0], {1'b0, lo_v[0]}));
    for (int c = 0; c < 9; c++) tick();
    chk("ah_held", la_data_out, mk(2'b11, 8'd1, lo_p[0], {1'b0, lo_v[0]}));
    cmd(START); tick();
    chk("ah_start_ign", la_data_out, mk(2'b11, 8'd1, lo_p[0], {1'b0, lo_v[0]}));
    cmd(ACK_EVEN); tick();
    chk("ah_even_ign", la_data_out, mk(2'b11, 8'd1, lo_p[0], {1'b0, lo_v[0]}));
    cmd(ACK_ODD); tick();
    chk("ah_c2", la_data_out, mk(2'b11, 8'd2, hi_p[1], hi_v[1]));

    // Busy ignore: new data offered while sending
    res_data = ~rich; res_valid = 1'b1; tick();
    chk("busy_ready", {127'h0, res_ready}, 128'h0);
    res_valid = 1'b0;
    cmd(ACK_EVEN); tick();
    chk("busy_c3", la_data_out, mk(2'b11, 8'd3, lo_p[1], {1'b0, lo_v[1]}));

    // Abort at index 3
    cmd(ABORT); tick();
    chk("ab_out", la_data_out, 128'h0);
    chk("ab_ready", {127'h0, res_ready}, 128'h1);
    chk("ab_nodone", {127'h0, rd_done}, 128'h0);

    // Restart and send everything
    cmd(RELEASE); res_data = rich; res_valid = 1'b1; tick(); res_valid = 1'b0;
    cmd(START); tick();
    chk("rs_c0", la_data_out, mk(2'b11, 8'd0, hi_p[0], hi_v[0]));
    for (int i = 0; i < 7; i++) begin
      cmd(i[0] ? ACK_ODD : ACK_EVEN); tick();
      if (i[0])
        chk($sformatf("rs_c%0d", i + 1), la_data_out,
            mk(2'b11, 8'(i + 1), hi_p[(i + 1) / 2], hi_v[(i + 1) / 2]));
      else
        chk($sformatf("rs_c%0d", i + 1), la_data_out,
            mk(2'b11, 8'(i + 1), lo_p[i / 2], {1'b0, lo_v[i / 2]}));
    end
    cmd(ACK_ODD); tick();
    chk("rs_done_pulse", {127'h0, rd_done}, 128'h1);
    cmd(ABORT); tick();
    chk("rs_abort_done", la_data_out, 128'h0);
    chk("rs_abort_nodone", {127'h0, rd_done}, 128'h0);

    // Gated START
    cmd(RELEASE); res_valid = 1'b1; tick(); res_valid = 1'b0;
    la_oenb = {96'h0, 16'hFFFF, 16'h0}; cmd(START); tick();
    chk("gate_loaded", la_data_out, mk(2'b01, 8'd0, 1'b0, 82'h0));
    la_oenb = '0; tick();
    chk("gate_open", la_data_out, mk(2'b11, 8'd0, hi_p[0], hi_v[0]));

    // Reset mid-SEND
    cmd(ACK_EVEN); tick();
    #2 wb_rst_n = 1'b0; #1;
    chk("mr_out", la_data_out, 128'h0);
    chk("mr_ready", {127'h0, res_ready}, 128'h1);
    chk("mr_done", {127'h0, rd_done}, 128'h0);
    tick(); wb_rst_n = 1'b1; cmd(RELEASE); tick();
    chk("mr_idle", la_data_out, 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
